// File: rtl/fpu_round_pack_if.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_round_pack_if
//  Purpose  : Input/output valid-ready bundle for the FPU round/pack stage.
//  Revision : 1.0  initial release
// ============================================================================
interface fpu_round_pack_if #(
  parameter int EXP_W  = 11,
  parameter int FRAC_W = 20
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_sign;
  logic [EXP_W-1:0]        in_exp;
  logic [FRAC_W+3:0]       in_mant;
  logic                    in_sticky;
  logic                    out_valid;
  logic                    out_ready;
  logic [EXP_W+FRAC_W:0]   data_out;
  logic [3:0]              status_out;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_sticky, out_ready,
    input  in_ready, out_valid, data_out, status_out
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_sticky, out_ready,
    output in_ready, out_valid, data_out, status_out
  );
endinterface
`default_nettype wire

// File: rtl/fpu_round_pack.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_round_pack
//  Purpose  : Normalize (one bit per clock), round-to-nearest-even and pack an
//             FPU adder result. Define FPU_SATURATE_EN to saturate overflow to
//             max finite instead of infinity.
//  Revision : 1.0  initial release
// ============================================================================
module fpu_round_pack #(
  parameter int EXP_W  = 11,
  parameter int FRAC_W = 20
) (
  input  wire logic         clock_100k,
  input  wire logic         reset,
  fpu_round_pack_if.slave   bus
);

  localparam int MW = FRAC_W + 4;
  localparam int XW = EXP_W + 1;
  localparam int DW = 1 + EXP_W + FRAC_W;
  localparam logic [XW-1:0] EXP_ONE = XW'(1);
  localparam logic [XW-1:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_sign;
  logic [XW-1:0]   r_exp;
  logic [MW-1:0]   r_mant;
  logic            r_sticky;
  logic            r_zero;
  logic            r_unf;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [DW-1:0]   r_data;
  logic [3:0]      r_status;

  logic [FRAC_W-1:0] w_frac;
  logic              w_guard;
  logic              w_rbit;
  logic              w_up;
  logic [FRAC_W:0]   w_frac_inc;
  logic [XW-1:0]     w_exp_rnd;
  logic              w_inexact;
  logic              w_ovf;
  logic [DW-1:0]     w_ovf_data;
  logic [DW-1:0]     w_result;
  logic [3:0]        w_status;

  assign w_frac     = r_mant[FRAC_W+1:2];
  assign w_guard    = r_mant[1];
  assign w_rbit     = r_mant[0] | r_sticky;
  assign w_up       = w_guard & (w_rbit | w_frac[0]);
  // A carry out of the fraction means it was all ones; the low bits are then 0.
  assign w_frac_inc = {1'b0, w_frac} + {{FRAC_W{1'b0}}, w_up};
  assign w_exp_rnd  = r_exp + {{EXP_W{1'b0}}, w_frac_inc[FRAC_W]};
  assign w_inexact  = w_guard | w_rbit;
  assign w_ovf      = (w_exp_rnd >= EXP_MAX);

`ifdef FPU_SATURATE_EN
  assign w_ovf_data = {r_sign, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
`else
  assign w_ovf_data = {r_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
`endif

  // Status order is {EXACT, OVERFLOW, UNDERFLOW, INEXACT}.
  always_comb begin
    w_result = '0;
    w_status = 4'b0000;
    if (r_zero) begin
      w_result = '0;
      w_status = 4'b1000;
    end else if (r_unf) begin
      w_result = {r_sign, {(EXP_W+FRAC_W){1'b0}}};
      w_status = 4'b0011;
    end else if (w_ovf) begin
      w_result = w_ovf_data;
      w_status = 4'b0101;
    end else begin
      w_result = {r_sign, w_exp_rnd[EXP_W-1:0], w_frac_inc[FRAC_W-1:0]};
      w_status = {~w_inexact, 2'b00, w_inexact};
    end
  end

  always_ff @(posedge clock_100k or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_mant      <= '0;
      r_sticky    <= 1'b0;
      r_zero      <= 1'b0;
      r_unf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_data      <= '0;
      r_status    <= 4'b0000;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_sign     <= bus.in_sign;
            r_exp      <= {1'b0, bus.in_exp};
            r_mant     <= bus.in_mant;
            r_sticky   <= bus.in_sticky;
            r_zero     <= 1'b0;
            r_unf      <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= NORM;
          end
        end
        NORM: begin
          if (r_mant == '0) begin
            r_zero  <= 1'b1;
            r_state <= ROUND;
          end else if (r_mant[MW-1]) begin
            r_mant   <= r_mant >> 1;
            r_sticky <= r_sticky | r_mant[0];
            r_exp    <= r_exp + EXP_ONE;
          end else if (!r_mant[MW-2]) begin
            if (r_exp > EXP_ONE) begin
              r_mant <= r_mant << 1;
              r_exp  <= r_exp - EXP_ONE;
            end else begin
              r_unf   <= 1'b1;
              r_state <= ROUND;
            end
          end else begin
            r_state <= ROUND;
          end
        end
        ROUND: begin
          r_data      <= w_result;
          r_status    <= w_status;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.data_out   = r_data;
  assign bus.status_out = r_status;

endmodule
`default_nettype wire
